serial_add_seq: RTL
===================

Name: serial_add_seq

Overview:
- Sequencer for a bit-serial addition datapath built around an external combinational 1-bit full-adder cell.
- Accepts parallel WIDTH-bit operands on a start handshake and feeds them LSB-first into the cell, one bit per clock.
- Owns the inter-bit carry register, assembles the serial sum back into parallel form, and reports completion.
- Sits between the parallel operand source and the 1-bit adder cell; it is the only driver of the cell inputs.

Parameters:
- WIDTH, 4, operand/sum width in bits; legal range WIDTH >= 2.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- start  input  1  request a new addition; sampled on clk when not busy
- a  input  WIDTH  operand A; sampled on accepted start
- b  input  WIDTH  operand B; sampled on accepted start
- cin  input  1  initial carry; sampled on accepted start
- fa_a  output  1  bit of A presented to the adder cell
- fa_b  output  1  bit of B presented to the adder cell
- fa_cin  output  1  carry presented to the adder cell
- fa_sum  input  1  sum bit returned by the adder cell, combinational
- fa_cout  input  1  carry-out returned by the adder cell, combinational
- busy  output  1  high while shifting; start ignored
- done  output  1  one-cycle pulse; sum/cout valid
- sum  output  WIDTH  result, held until next completion
- cout  output  1  final carry-out, held until next completion

Behaviour:
- Reset is clk and rst, with rst asynchronous and active-high. It is asserted asynchronously and takes effect immediately in any state.
- Reset values: state IDLE; busy=0, done=0, sum=0, cout=0, fa_a=fa_b=fa_cin=0. Internal shift registers, carry and bit counter are 0.
- Reset mid-operation aborts the operation. No done is produced, and sum/cout return to 0.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - fa_* outputs are driven 0.
  - When start=1 at a clk edge, capture a, b into shift registers, load carry <= cin, clear the counter, and go to SHIFT.
- SHIFT:
  - busy=1.
  - fa_a = shift_a[0], fa_b = shift_b[0], fa_cin = carry.
  - Each edge: the sum accumulator shifts right with fa_sum entering the MSB; carry <= fa_cout; shift_a and shift_b shift right; counter increments.
  - At the edge where counter == WIDTH-1: sum <= {fa_sum, accumulator[WIDTH-1:1]}, cout <= fa_cout, then go to DONE.
  - start is ignored.
- DONE:
  - done=1 for exactly this one cycle; busy=0; fa_* driven 0.
  - If start=1 at this edge, it is accepted as in IDLE (back-to-back, next state SHIFT). Otherwise go to IDLE.
- Latency: start accepted at edge E0 → busy high E0..EW → done high the cycle after EW. That is WIDTH+1 cycles from acceptance to done, and the throughput is one result per WIDTH+1 cycles.
- sum/cout change only on the SHIFT→DONE transition (or reset). They stay stable through IDLE and the next operation until the next completion.
- Arithmetic: sum = (a + b + cin) mod 2^WIDTH; cout = bit WIDTH of the full sum.
- Counter width is $clog2(WIDTH). No wrap beyond WIDTH-1 occurs.

Optional Feature:
- Macro: SERIAL_ADD_SUB_EN
- Defined:
  - Adds port op_sub (input, 1), sampled with start.
  - When op_sub=1: B is captured inverted (~b) and the carry is loaded with 1, ignoring cin. The result is sum = a - b mod 2^WIDTH, and cout = 1 means no borrow.
  - When op_sub=0: behaviour is identical to the undefined case.
- Undefined: no op_sub port; addition only.

Test Plan:
- WIDTH=4, start with a=5, b=3, cin=0 → busy for 4 cycles, fa_a sequence 1,0,1,0; done pulse on cycle 5 with sum=8, cout=0.
- a=15, b=1, cin=0 → sum=0, cout=1; a=7, b=8, cin=1 → sum=0, cout=1.
- Start pulsed again during busy with a=1, b=1 → ignored; first result 5+3=8 is unchanged. Start held high in the DONE cycle with a=2, b=2 → second done exactly 5 cycles later with sum=4.
- Assert rst during the 2nd SHIFT cycle → busy=0, done never pulses, sum=0, cout=0. A subsequent start with a=9, b=6 → sum=15, cout=0.
- With SERIAL_ADD_SUB_EN: op_sub=1, a=5, b=3 → sum=2, cout=1. op_sub=1, a=3, b=5 → sum=14, cout=0.
- WIDTH=8, a=200, b=100, cin=0 → busy 8 cycles, sum=44, cout=1.

Source files
------------

// File: rtl/serial_add_seq.sv
// Bit-serial addition sequencer: feeds an external 1-bit full-adder cell LSB-first and reassembles the sum.
// Optional subtract mode (op_sub port) is compiled in with SERIAL_ADD_SUB_EN.
module serial_add_seq #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             op_sub,
`endif
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_sum,
    input  logic             fa_cout,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_d;
    logic [WIDTH-1:0] shift_a;
    logic [WIDTH-1:0] shift_a_d;
    logic [WIDTH-1:0] shift_b;
    logic [WIDTH-1:0] shift_b_d;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_d;
    logic [WIDTH-1:0] sum_d;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_d;
    logic             carry;
    logic             carry_d;
    logic             cout_d;
    logic             busy_d;
    logic             done_d;
    logic             op_sub_i;
    logic             accept;
    logic             last;
    logic [WIDTH-1:0] b_load;
    logic             c_load;

`ifdef SERIAL_ADD_SUB_EN
    assign op_sub_i = op_sub;
`else
    assign op_sub_i = 1'b0;
`endif

    // Subtraction is a + ~b + 1; the cell itself only ever adds.
    assign b_load = op_sub_i ? ~b : b;
    assign c_load = op_sub_i ? 1'b1 : cin;

    assign accept = start && ((state == IDLE) || (state == DONE));
    assign last   = (state == SHIFT) && (cnt == CNT_W'(WIDTH - 1));

    // Shift registers and carry are zeroed outside SHIFT, so the cell inputs idle at 0.
    assign fa_a   = shift_a[0];
    assign fa_b   = shift_b[0];
    assign fa_cin = carry;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT:   if (last)  state_d = DONE;
            DONE:    state_d = start ? SHIFT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output and datapath next values
    always_comb begin
        shift_a_d = shift_a;
        shift_b_d = shift_b;
        acc_d     = acc;
        carry_d   = carry;
        cnt_d     = cnt;
        sum_d     = sum;
        cout_d    = cout;
        busy_d    = (state_d == SHIFT);
        done_d    = (state_d == DONE);
        if (accept) begin
            shift_a_d = a;
            shift_b_d = b_load;
            carry_d   = c_load;
            cnt_d     = '0;
            acc_d     = '0;
        end else if (state == SHIFT) begin
            acc_d     = {fa_sum, acc[WIDTH-1:1]};
            shift_a_d = shift_a >> 1;
            shift_b_d = shift_b >> 1;
            carry_d   = fa_cout;
            cnt_d     = cnt + CNT_W'(1);
            if (last) begin
                sum_d     = {fa_sum, acc[WIDTH-1:1]};
                cout_d    = fa_cout;
                shift_a_d = '0;
                shift_b_d = '0;
                carry_d   = 1'b0;
                cnt_d     = '0;
            end
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_a <= '0;
            shift_b <= '0;
            acc     <= '0;
            carry   <= 1'b0;
            cnt     <= '0;
            sum     <= '0;
            cout    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            shift_a <= shift_a_d;
            shift_b <= shift_b_d;
            acc     <= acc_d;
            carry   <= carry_d;
            cnt     <= cnt_d;
            sum     <= sum_d;
            cout    <= cout_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

endmodule
